// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and requester ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; remembers the last grant and alternates on ties.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       gnt,
    output logic       valid
);

    logic last_q, last_d;

    always_comb begin
        valid  = req[PORT_C] | req[PORT_D];
        // On a tie the port that did not win last time goes next, so neither starves.
        gnt    = (req[PORT_C] && req[PORT_D]) ? ~last_q : req[PORT_D];
        last_d = upd ? gnt : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DataMemory port between the core (C) and debug/loader (D) requesters.
// Define DMEM_ARB_PERF_EN to add saturating per-port access and conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_a,
    input  logic [DW-1:0] c_wd,
    input  logic          c_bw,
    input  logic          c_bws,
    output logic          c_ack,
    output logic [DW-1:0] c_rd,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_a,
    input  logic [DW-1:0] d_wd,
    input  logic          d_bw,
    input  logic          d_bws,
    output logic          d_ack,
    output logic [DW-1:0] d_rd,
    output logic [AW-1:0] m_a,
    output logic [DW-1:0] m_wd,
    output logic          m_we,
    output logic          m_bw,
    output logic          m_bws,
    input  logic [DW-1:0] m_rd,
    output logic          busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] c_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          bw;
        logic          bws;
    } cmd_t;

    state_e        state_q, state_d;
    logic          win_q, win_d;
    cmd_t          cmd_q, cmd_d;
    logic          m_we_q, m_we_d;
    logic          c_ack_q, c_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] c_rd_q, c_rd_d;
    logic [DW-1:0] d_rd_q, d_rd_d;

    logic arb_gnt, arb_valid, arb_upd;
    cmd_t c_cmd, d_cmd;

    assign c_cmd = '{we: c_we, a: c_a, wd: c_wd, bw: c_bw, bws: c_bws};
    assign d_cmd = '{we: d_we, a: d_a, wd: d_wd, bw: d_bw, bws: d_bws};

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req   ({d_req, c_req}),
        .upd   (arb_upd),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d = state_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        m_we_d  = 1'b0;
        c_ack_d = 1'b0;
        d_ack_d = 1'b0;
        c_rd_d  = c_rd_q;
        d_rd_d  = d_rd_q;
        arb_upd = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (arb_valid) begin
                    arb_upd = 1'b1;
                    win_d   = arb_gnt;
                    cmd_d   = (arb_gnt == PORT_D) ? d_cmd : c_cmd;
                    m_we_d  = cmd_d.we;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!cmd_q.we) begin
                    if (win_q == PORT_D) d_rd_d = m_rd;
                    else                 c_rd_d = m_rd;
                end
                c_ack_d = (win_q == PORT_C);
                d_ack_d = (win_q == PORT_D);
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments; the async reset clears every flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            win_q   <= PORT_C;
            cmd_q   <= '0;
            m_we_q  <= 1'b0;
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            c_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            m_we_q  <= m_we_d;
            c_ack_q <= c_ack_d;
            d_ack_q <= d_ack_d;
            c_rd_q  <= c_rd_d;
            d_rd_q  <= d_rd_d;
        end
    end

    assign m_a     = cmd_q.a;
    assign m_wd    = cmd_q.wd;
    assign m_bw    = cmd_q.bw;
    assign m_bws   = cmd_q.bws;
    assign m_we    = m_we_q;
    assign c_ack   = c_ack_q;
    assign d_ack   = d_ack_q;
    assign c_rd    = c_rd_q;
    assign d_rd    = d_rd_q;
    assign c_stall = c_req & ~c_ack_q;
    assign busy    = (state_q != IDLE);

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
    logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

    // Counters step in the cycle the ack/grant is decided and stick at all-ones.
    always_comb begin
        c_cnt_d    = c_cnt_q;
        d_cnt_d    = d_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (c_ack_d && !(&c_cnt_q)) c_cnt_d = c_cnt_q + CNT_W'(1);
        if (d_ack_d && !(&d_cnt_q)) d_cnt_d = d_cnt_q + CNT_W'(1);
        if (arb_upd && c_req && d_req && !(&conf_cnt_q)) conf_cnt_d = conf_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_cnt_q    <= '0;
            d_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else begin
            c_cnt_q    <= c_cnt_d;
            d_cnt_q    <= d_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign c_cnt        = c_cnt_q;
    assign d_cnt        = d_cnt_q;
    assign conflict_cnt = conf_cnt_q;
`endif

endmodule
